serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial multi-bit adder built from one instance of the team's single-bit full adder cell (`student_full_adder`, ports a, b, c, sum, carry). The controller latches two WIDTH-bit operands on a start handshake and steps them LSB-first through the cell, one bit per clock, keeping the carry in a flip-flop. It then presents the WIDTH-bit result and carry-out with a one-cycle done pulse. It is the area-minimal adder path for later ALU projects.

## Interface
- WIDTH, 16, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  operand A, latched at accepted start
- b  input  WIDTH  operand B, latched at accepted start
- sub  input  1  subtract select, latched at accepted start (present only with SERIAL_ADD_SUB_EN)
- sum  output  WIDTH  result; valid from done until next accepted start
- carry_out  output  1  final carry of the MSB step
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when result is valid

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start=1 → load A/B shift registers, clear result register, carry_ff=0 (=1 if sub with macro), bit counter=0, go RUN. start=0 → stay.
- RUN: cell inputs a=A[0], b=B[0] (inverted if sub), c=carry_ff. Each edge: result shifts right with cell sum into MSB; carry_ff←cell carry; A, B shift right; counter+1. When counter==WIDTH-1 on the edge, go DONE.
- DONE: done=1 for exactly this cycle. start=1 here is accepted exactly like IDLE (back-to-back). Otherwise go IDLE.
- start while RUN is ignored; operands are not re-latched.
- Arithmetic: sum = (A+B) mod 2^WIDTH; carry_out = bit WIDTH of A+B. No signed overflow flag.
- Counter width is clog2(WIDTH). It never wraps past WIDTH-1; it is cleared on every accepted start.
- sum/carry_out hold their value through DONE and IDLE until the next accepted start clears them.
- Reset mid-RUN: abort, return to IDLE, all outputs 0 on next cycle, no done pulse.

## Timing
- Reset values: sum=0, carry_out=0, busy=0, done=0, state IDLE.
- Accepted start at edge k: busy=1 for cycles k+1 … k+WIDTH (WIDTH cycles).
- done=1 during cycle k+WIDTH+1, with busy=0. Latency start→done = WIDTH+1 clocks.
- Throughput with back-to-back starts is one result per WIDTH+1 clocks.
- No combinational path from inputs to outputs. The cell is purely combinational between the registers.

## Configuration
- SERIAL_ADD_SUB_EN defined: `sub` port exists. sub=1 computes A−B as A+~B+1, with carry_ff initialised to 1 and B inverted at the cell input. carry_out=1 means no borrow.
- Undefined: no `sub` port; add only; carry_ff is always initialised to 0.

## Test plan
- Reset then idle for 5 clocks → sum=0, carry_out=0, busy=0, done=0 throughout.
- WIDTH=4, start with a=7, b=9 → busy for 4 cycles, done at start+5, sum=0x0, carry_out=1. Also a=0xF, b=0x1 → sum=0x0, carry_out=1. Also a=3, b=4 → sum=0x7, carry_out=0.
- WIDTH=4, a=5, b=6, then start pulsed again at cycles 2 and 3 of RUN with a=0xF → ignored; sum=0xB, done still at start+5.
- Start in the done cycle with new operands 1+1 → second done exactly 5 clocks later, sum=0x2. The first result 0xB is visible during the first done.
- Reset asserted at cycle 2 of RUN → next cycle busy=0, sum=0, no done pulse. A fresh start then yields the correct result.
- With SERIAL_ADD_SUB_EN, WIDTH=4: sub=1, a=3, b=5 → sum=0xE, carry_out=0. sub=1, a=9, b=4 → sum=0x5, carry_out=1. Exhaustive 4-bit add/sub checked against a reference model.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB-first, one bit per clock.
// Optional subtract support is compiled in with `define SERIAL_ADD_SUB_EN.

module student_full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg, co_reg;
    logic             sub_reg, sub_load;
    logic             accept, last_bit;
    logic             cell_b, cell_sum, cell_carry;

    // A start is honoured in IDLE and in DONE (back-to-back), never during RUN.
    assign accept   = start && (state_reg != RUN);
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
    assign sub_load = sub;
    always_ff @(posedge clk) begin
        if (reset)
            sub_reg <= 1'b0;
        else if (accept)
            sub_reg <= sub;
    end
`else
    assign sub_load = 1'b0;
    assign sub_reg  = 1'b0;
`endif

    // Subtraction is A + ~B + 1: invert B here, the +1 comes from the carry seed.
    assign cell_b = b_reg[0] ^ sub_reg;

    student_full_adder u_cell (
        .a     (a_reg[0]),
        .b     (cell_b),
        .c     (carry_reg),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == RUN);
        done = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            co_reg    <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            res_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= sub_load;
            co_reg    <= 1'b0;
        end else if (state_reg == RUN) begin
            // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH steps.
            res_reg   <= {cell_sum, res_reg[WIDTH-1:1]};
            a_reg     <= {1'b0, a_reg[WIDTH-1:1]};
            b_reg     <= {1'b0, b_reg[WIDTH-1:1]};
            carry_reg <= cell_carry;
            if (last_bit)
                co_reg <= cell_carry;
            else
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign sum       = res_reg;
    assign carry_out = co_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=4; subtract vectors run when SERIAL_ADD_SUB_EN is defined.

module tb_serial_adder_ctrl;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        int           d;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, start, sub;
    logic [W-1:0] a, b;
    logic [W-1:0] sum;
    logic         carry_out, busy, done;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                         input logic [W-1:0] es, input logic ec);
        exp_t it;
        it.s = es;
        it.c = ec;
        it.d = cyc + 1 + W;
        q.push_back(it);
        $display("issue a=%0h b=%0h sub=%0b -> expect sum=%0h co=%0b at cycle %0d", ia, ib, isub, es, ec, it.d);
        a = ia;
        b = ib;
        sub = isub;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input logic [W-1:0] es, input logic ec);
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL done_timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
        chk("hold_sum", sum, es);
        chk("hold_carry", carry_out, ec);
        chk("hold_done", done, 0);
    endtask

    // Monitor: busy window from the head transaction, and result check on every done.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_busy;
            exp_t it;
            exp_busy = 1'b0;
            if (q.size() > 0 && cyc >= q[0].d - W && cyc < q[0].d)
                exp_busy = 1'b1;
            chk("busy", busy, exp_busy);
            if (done) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_done: got done=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    it = q.pop_front();
                    $display("done cycle %0d sum=%0h co=%0b", cyc, sum, carry_out);
                    chk("sum", sum, it.s);
                    chk("carry_out", carry_out, it.c);
                    chk("done_cycle", cyc, it.d);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) step();
        reset = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            chk("rst_sum", sum, 0);
            chk("rst_carry", carry_out, 0);
            chk("rst_done", done, 0);
            step();
        end

        issue(4'h7, 4'h9, 1'b0, 4'h0, 1'b1); wait_done(4'h0, 1'b1);
        issue(4'hF, 4'h1, 1'b0, 4'h0, 1'b1); wait_done(4'h0, 1'b1);
        issue(4'h3, 4'h4, 1'b0, 4'h7, 1'b0); wait_done(4'h7, 1'b0);
        issue(4'hA, 4'h5, 1'b0, 4'hF, 1'b0); wait_done(4'hF, 1'b0);
        issue(4'h8, 4'h8, 1'b0, 4'h0, 1'b1); wait_done(4'h0, 1'b1);
        issue(4'hF, 4'hF, 1'b0, 4'hE, 1'b1); wait_done(4'hE, 1'b1);
        issue(4'h0, 4'h0, 1'b0, 4'h0, 1'b0); wait_done(4'h0, 1'b0);

        // Starts during RUN cycles 2 and 3 are ignored; then back-to-back start in DONE.
        issue(4'h5, 4'h6, 1'b0, 4'hB, 1'b0);
        step();
        a = 4'hF;
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        step();
        chk("done_in_b2b", done, 1);
        chk("first_sum_in_done", sum, 4'hB);
        issue(4'h1, 4'h1, 1'b0, 4'h2, 1'b0);
        wait_done(4'h2, 1'b0);

        // Reset in RUN cycle 2 aborts with no done pulse.
        issue(4'h5, 4'h6, 1'b0, 4'hB, 1'b0);
        step();
        reset = 1'b1;
        step();
        q.delete();
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_carry", carry_out, 0);
        chk("abort_done", done, 0);
        repeat (6) step();
        issue(4'h3, 4'h4, 1'b0, 4'h7, 1'b0); wait_done(4'h7, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        issue(4'h3, 4'h5, 1'b1, 4'hE, 1'b0); wait_done(4'hE, 1'b0);
        issue(4'h9, 4'h4, 1'b1, 4'h5, 1'b1); wait_done(4'h5, 1'b1);
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    logic [W:0] r;
                    if (s == 1)
                        r = {1'b0, 4'(x)} + {1'b0, ~4'(y)} + 5'd1;
                    else
                        r = {1'b0, 4'(x)} + {1'b0, 4'(y)};
                    issue(4'(x), 4'(y), 1'(s), r[W-1:0], r[W]);
                    wait_done(r[W-1:0], r[W]);
                end
            end
        end
`endif

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
